// File: rtl/symbol_buffer_reader.sv
// Frame readout of the symbol command buffer: snapshots the valid mask on frame_start and
// streams each valid symbol ID plus its attribute word over a valid/ready handshake.
module symbol_buffer_reader #(
   parameter int  NUM_SYMS            = 8,
   parameter int  PROG_PAYLD_PKT_BITS = 32,
   localparam int ID_BITS             = $clog2(NUM_SYMS)
) (
   input  logic                           i_clk,
   input  logic                           n_btn_reset,
   input  logic                           frame_start,
   input  logic [NUM_SYMS-1:0]            valid_prog_idx,
   input  logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer [0:NUM_SYMS-1],
   output logic                           sym_valid,
   input  logic                           sym_ready,
   output logic [ID_BITS-1:0]             sym_id,
   output logic [PROG_PAYLD_PKT_BITS-1:0] sym_attr,
   output logic                           sym_last,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           overrun,
   output logic [1:0]                     state_dbg
);

   // Handshake: a symbol moves on every cycle where sym_valid & sym_ready are both high.
   // Once raised, sym_valid and the payload stay fixed until that transfer happens.

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

   state_t                           state, state_nxt;
   logic [ID_BITS-1:0]               idx, idx_nxt;
   logic [NUM_SYMS-1:0]              mask, mask_nxt;
   logic                             valid_nxt, last_nxt, overrun_nxt, above;
   logic [ID_BITS-1:0]               id_nxt;
   logic [PROG_PAYLD_PKT_BITS-1:0]   attr_nxt;

   // Any frozen-mask bit set above the slot being examined?
   always_comb begin
      above = 1'b0;
      for (int i = 0; i < NUM_SYMS; i++)
         if (i > int'(idx) && mask[i]) above = 1'b1;
   end

   always_ff @(posedge i_clk or negedge n_btn_reset) begin
      if (!n_btn_reset) begin
         state     <= IDLE;
         idx       <= '0;
         mask      <= '0;
         sym_valid <= 1'b0;
         sym_id    <= '0;
         sym_attr  <= '0;
         sym_last  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         mask      <= mask_nxt;
         sym_valid <= valid_nxt;
         sym_id    <= id_nxt;
         sym_attr  <= attr_nxt;
         sym_last  <= last_nxt;
         overrun   <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      mask_nxt    = mask;
      valid_nxt   = sym_valid;
      id_nxt      = sym_id;
      attr_nxt    = sym_attr;
      last_nxt    = sym_last;
      overrun_nxt = overrun | (frame_start & (state != IDLE));
      case (state)
         IDLE: begin
            if (frame_start) begin
               mask_nxt  = valid_prog_idx;
               idx_nxt   = '0;
               state_nxt = (|valid_prog_idx) ? SCAN : DONE;
            end
         end
         SCAN: begin
            if (mask[idx]) begin
               id_nxt    = idx;
               attr_nxt  = prog_buffer[idx];
               last_nxt  = ~above;
               valid_nxt = 1'b1;
               state_nxt = EMIT;
            end else begin
               idx_nxt = idx + ID_BITS'(1);
            end
         end
         EMIT: begin
            if (sym_ready) begin
               valid_nxt = 1'b0;
               if (sym_last) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt   = idx + ID_BITS'(1);
                  state_nxt = SCAN;
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);
   assign state_dbg  = state;

endmodule
